// File: rtl/bcd2bin_pkg.sv
// rtl/bcd2bin_pkg.sv - shared state encoding and sizing for the BCD-to-binary converter
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_OP     = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int DEFAULT_DIGITS = 5;
  localparam int DEFAULT_BIN_W  = 20;

endpackage

// File: rtl/bcd_digit_sub3.sv
// rtl/bcd_digit_sub3.sv - per-digit reverse double-dabble correction (d>=8 ? d-3 : d)
module bcd_digit_sub3
  import bcd2bin_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= BCD_DIGIT_W'(8)) ? d_i - BCD_DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - sequential BCD-to-binary converter (reverse double dabble, start/busy/done)
module bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS,
  parameter int BIN_W  = DEFAULT_BIN_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]              bin,
  output logic                          done,
  output logic                          busy,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BCD_W);
  localparam int ALIGN = (BIN_W > BCD_W) ? (BIN_W - BCD_W) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BCD_W - 1);

  state_e           state_q;
  logic [SR_W-1:0]  sreg_q;
  logic [SR_W-1:0]  sreg_d;
  logic [SR_W-1:0]  shifted;
  logic [CNT_W-1:0] cnt_q;
  logic             err_r_q;
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W-1:0] bin_d;
  logic             done_q;
  logic             busy_q;
  logic             err_q;
  logic [DIGITS-1:0] bad_digit;
  logic             bad_any;

  // Correction is applied to the BCD field only, after the shift.
  assign shifted            = sreg_q >> 1;
  assign sreg_d[BIN_W-1:0]  = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .d_i (shifted[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .d_o (sreg_d[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
    assign bad_digit[g] = bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W] > BCD_DIGIT_W'(9);
  end

  assign bad_any = |bad_digit;
  assign bin_d   = err_r_q ? '0 : (sreg_q[BIN_W-1:0] >> ALIGN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      err_r_q <= 1'b0;
      bin_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sreg_q  <= {bcd, {BIN_W{1'b0}}};
            cnt_q   <= CNT_LOAD;
            err_r_q <= bad_any;
            busy_q  <= 1'b1;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          sreg_q <= sreg_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          bin_q   <= bin_d;
          done_q  <= 1'b1;
          err_q   <= err_r_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bin  = bin_q;
  assign done = done_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb/tb_bcd2bin.sv - self-checking bench for bcd2bin: vector table, corner sequences, random vs model
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] bcd;
  logic [19:0] bin;
  logic        done;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  bcd2bin #(.DIGITS(5), .BIN_W(20)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic [19:0] bin;
    logic        err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Decimal value of each digit weighted by its power of ten.
  function automatic void model(input logic [19:0] v, output logic [19:0] b, output logic e);
    int acc;
    acc = 0;
    e   = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      int d;
      d = int'(v[4*i +: 4]);
      if (d > 9) e = 1'b1;
      acc = acc * 10 + d;
    end
    b = e ? 20'd0 : 20'(acc);
  endfunction

  task automatic run_conv(input logic [19:0] v, input logic [19:0] exp_bin, input logic exp_err,
                          input bit poke, input string nm);
    int  lat;
    int  extra;
    bit  busy_ok;
    start = 1'b1;
    bcd   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bcd   = 20'($urandom);
    chk({nm, "_busy_after_accept"}, 32'(busy), 32'd1);
    busy_ok = 1'b1;
    lat     = 0;
    for (int k = 1; k <= 40; k++) begin
      start = (poke && (k == 5 || k == 15)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'd21);
    chk({nm, "_busy_span"}, 32'(busy_ok), 32'd1);
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, "_bin"}, 32'(bin), 32'(exp_bin));
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    if (poke) begin
      extra = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      chk({nm, "_no_extra_done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          npulse;
    int          pcyc[3];
    logic [19:0] pbin[3];
    logic [19:0] rv;
    logic [19:0] eb;
    logic        ee;

    tbl[0] = '{20'h12345, 20'h03039, 1'b0};
    tbl[1] = '{20'h99999, 20'h1869F, 1'b0};
    tbl[2] = '{20'h00000, 20'h00000, 1'b0};
    tbl[3] = '{20'h1A000, 20'h00000, 1'b1};
    tbl[4] = '{20'h00042, 20'h0002A, 1'b0};
    tbl[5] = '{20'h00100, 20'h00064, 1'b0};

    rst   = 1'b0;
    start = 1'b0;
    bcd   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bin",  32'(bin),  32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err",  32'(err),  32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_conv(tbl[i].bcd, tbl[i].bin, tbl[i].err, 1'b0, $sformatf("vec%0d", i));
    end

    // Abort mid-conversion with a one-cycle reset at E10.
    start = 1'b1;
    bcd   = 20'h54321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_bin",  32'(bin),  32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    run_conv(20'h00007, 20'h00007, 1'b0, 1'b0, "after_abort");

    run_conv(20'h00321, 20'h00141, 1'b0, 1'b1, "poke");

    // start held high; bcd changes while the second conversion is running.
    bcd    = 20'h00100;
    start  = 1'b1;
    npulse = 0;
    for (int c = 0; c <= 70; c++) begin
      @(posedge clk); #1;
      if (c == 27) bcd = 20'h00200;
      if (done) begin
        if (npulse < 3) begin
          pcyc[npulse] = c;
          pbin[npulse] = bin;
        end
        npulse++;
      end
      if (c == 65) start = 1'b0;
    end
    chk("held_pulses", 32'(npulse), 32'd3);
    if (npulse >= 3) begin
      chk("held_cyc0", 32'(pcyc[0]), 32'd21);
      chk("held_cyc1", 32'(pcyc[1]), 32'd43);
      chk("held_cyc2", 32'(pcyc[2]), 32'd65);
      chk("held_bin0", 32'(pbin[0]), 32'h64);
      chk("held_bin1", 32'(pbin[1]), 32'h64);
      chk("held_bin2", 32'(pbin[2]), 32'hC8);
    end

    for (int n = 0; n < 24; n++) begin
      for (int d = 0; d < 5; d++) rv[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) begin
        int p;
        p = int'($urandom_range(0, 4));
        rv[4*p +: 4] = 4'($urandom_range(10, 15));
      end
      model(rv, eb, ee);
      run_conv(rv, eb, ee, 1'b0, $sformatf("rand%0d_%h", n, rv));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
